// File: rtl/turn_pkg.sv
// Shared constants for the turn scheduler: state encoding, player count, defaults,
// and the round-robin player search used by the FSM.
package turn_pkg;

  localparam int NUM_PLAYERS       = 4;
  localparam int DEF_TIMEOUT_TICKS = 1000;
  localparam int DEF_NUM_ROUNDS    = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_ACTIVE  = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // First enabled player after cur (1-based), wrapping 4 -> 1; 0 if none enabled.
  function automatic logic [2:0] next_player(input logic [2:0] cur, input logic [3:0] en);
    logic [2:0] nxt;
    logic [1:0] idx;
    logic       found;
    nxt   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PLAYERS; k++) begin
      idx = 2'(cur + 3'(k) - 3'd1);
      if (!found && en[idx]) begin
        nxt   = {1'b0, idx} + 3'd1;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for the shared controller buttons plus a rising-edge
// detector on the synchronized vector.
module button_sync (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] Buttons,
  output logic [2:0] Synced,
  output logic [2:0] Rise
);

  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic [2:0] prev_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= Buttons;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign Synced = sync_q;
  assign Rise   = sync_q & ~prev_q;

endmodule

// File: rtl/turn_scheduler.sv
// Round-robin turn scheduler for up to four players sharing one button controller,
// with per-turn tick timeout and a round counter that ends the game.
//
// state    | meaning
// IDLE     | waiting for Start with at least one enabled player
// ARM      | player selected, waiting for all buttons released
// ACTIVE   | turn running: press accepts a move, timer expiry forces advance
// ADVANCE  | pick next enabled player, count rounds on wrap
// DONE     | one-cycle GameOver, then back to IDLE
module turn_scheduler
  import turn_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int NUM_ROUNDS    = DEF_NUM_ROUNDS
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] PlayerEnable,
  input  logic       Tick,
  input  logic [2:0] ButtonVector,
  output logic [2:0] Select,
  output logic       TurnStart,
  output logic       MoveValid,
  output logic [2:0] MoveCode,
  output logic       TurnTimeout,
  output logic [7:0] RoundCount,
  output logic       GameOver,
  output logic       Busy
);

  localparam int            TW         = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]    ROUNDS_END = 8'(NUM_ROUNDS);

  logic [2:0] synced;
  logic [2:0] rise;
  logic       press;

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic          turn_start_q, turn_start_d;
  logic          move_valid_q, move_valid_d;
  logic [2:0]    move_code_q, move_code_d;
  logic          timeout_q, timeout_d;
  logic          game_over_q, game_over_d;
  logic [7:0]    round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [2:0] nxt_player;
  logic [7:0] round_inc;

  button_sync u_button_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .Buttons (ButtonVector),
    .Synced  (synced),
    .Rise    (rise)
  );

  assign press      = |rise;
  assign nxt_player = next_player(sel_q, PlayerEnable);
  assign round_inc  = (round_q == 8'hFF) ? round_q : round_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    turn_start_d = 1'b0;
    move_valid_d = 1'b0;
    move_code_d  = move_code_q;
    timeout_d    = 1'b0;
    game_over_d  = 1'b0;
    round_d      = round_q;
    timer_d      = timer_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = 3'd0;
        if (Start && (PlayerEnable != 4'd0)) begin
          state_d      = ST_ARM;
          sel_d        = next_player(3'd4, PlayerEnable);
          turn_start_d = 1'b1;
          round_d      = 8'd0;
        end
      end
      ST_ARM: begin
        timer_d = '0;
        if (synced == 3'd0) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (Tick) timer_d = timer_q + TW'(1);
        // A press beats a timeout landing in the same cycle.
        if (press) begin
          move_valid_d = 1'b1;
          move_code_d  = synced;
          state_d      = ST_ADVANCE;
        end else if (Tick && (timer_q == TIMER_LAST)) begin
          timeout_d = 1'b1;
          state_d   = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (PlayerEnable == 4'd0) begin
          state_d     = ST_DONE;
          sel_d       = 3'd0;
          game_over_d = 1'b1;
        end else begin
          if (nxt_player <= sel_q) round_d = round_inc;
          if ((nxt_player <= sel_q) && (round_inc == ROUNDS_END)) begin
            state_d     = ST_DONE;
            sel_d       = 3'd0;
            game_over_d = 1'b1;
          end else begin
            state_d      = ST_ARM;
            sel_d        = nxt_player;
            turn_start_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        sel_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        sel_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 3'd0;
      turn_start_q <= 1'b0;
      move_valid_q <= 1'b0;
      move_code_q  <= 3'd0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
      round_q      <= 8'd0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      turn_start_q <= turn_start_d;
      move_valid_q <= move_valid_d;
      move_code_q  <= move_code_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
      round_q      <= round_d;
      timer_q      <= timer_d;
    end
  end

  assign Select      = sel_q;
  assign TurnStart   = turn_start_q;
  assign MoveValid   = move_valid_q;
  assign MoveCode    = move_code_q;
  assign TurnTimeout = timeout_q;
  assign RoundCount  = round_q;
  assign GameOver    = game_over_q;
  assign Busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed scenarios plus random games
// checked against a turn-level model of player rotation and round counting.
module tb_turn_scheduler;

  localparam int TO_TICKS = 3;
  localparam int N_ROUNDS = 2;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [3:0] PlayerEnable;
  logic       Tick;
  logic [2:0] ButtonVector;
  logic [2:0] Select;
  logic       TurnStart;
  logic       MoveValid;
  logic [2:0] MoveCode;
  logic       TurnTimeout;
  logic [7:0] RoundCount;
  logic       GameOver;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_sel;
  logic [7:0] exp_rounds;

  turn_scheduler #(.TIMEOUT_TICKS(TO_TICKS), .NUM_ROUNDS(N_ROUNDS)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .PlayerEnable (PlayerEnable),
    .Tick         (Tick),
    .ButtonVector (ButtonVector),
    .Select       (Select),
    .TurnStart    (TurnStart),
    .MoveValid    (MoveValid),
    .MoveCode     (MoveCode),
    .TurnTimeout  (TurnTimeout),
    .RoundCount   (RoundCount),
    .GameOver     (GameOver),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  function automatic logic [2:0] lowest_player(input logic [3:0] en);
    for (int p = 1; p <= 4; p++) if (en[p-1]) return 3'(p);
    return 3'd0;
  endfunction

  // Next higher enabled player, otherwise wrap to the lowest enabled one.
  function automatic void model_next(input logic [2:0] cur, input logic [3:0] en,
                                     output logic [2:0] nxt, output bit wrap);
    nxt  = 3'd0;
    wrap = 1'b0;
    for (int p = int'(cur) + 1; p <= 4; p++) if (nxt == 3'd0 && en[p-1]) nxt = 3'(p);
    if (nxt == 3'd0) begin
      wrap = 1'b1;
      nxt  = lowest_player(en);
    end
  endfunction

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0; Tick = 1'b0; ButtonVector = 3'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic start_game(input logic [3:0] en);
    PlayerEnable = en;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    exp_sel    = lowest_player(en);
    exp_rounds = 8'd0;
    check_eq("start_turnstart", TurnStart, 1);
    check_eq("start_select", Select, exp_sel);
    check_eq("start_rounds", RoundCount, 0);
    check_eq("start_busy", Busy, 1);
  endtask

  task automatic wait_move(output int lat);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clock);
      if (MoveValid === 1'b1) begin
        lat = i;
        return;
      end
    end
    check_eq("mv_wait", MoveValid, 1);
    finish_run();
  endtask

  task automatic do_turn(input bit use_to, input logic [2:0] v, input logic [3:0] new_en,
                         output bit done);
    logic [2:0] nxt;
    bit         wrap;
    int         lat;
    done = 1'b0;
    repeat (4) begin
      Start = 1'($urandom_range(0, 1));
      @(negedge Clock);
    end
    Start = 1'b0;
    PlayerEnable = new_en;
    if (!use_to) begin
      ButtonVector = v;
      wait_move(lat);
      check_eq("mv_latency", lat, 3);
      check_eq("mv_code", MoveCode, v);
      check_eq("mv_no_timeout", TurnTimeout, 0);
      ButtonVector = 3'd0;
    end else begin
      for (int i = 1; i <= TO_TICKS; i++) begin
        Tick = 1'b1;
        @(negedge Clock);
        Tick = 1'b0;
        check_eq("to_pulse", TurnTimeout, (i == TO_TICKS));
        if (i < TO_TICKS) @(negedge Clock);
      end
    end
    if (new_en == 4'd0) done = 1'b1;
    else begin
      model_next(exp_sel, new_en, nxt, wrap);
      if (wrap) exp_rounds = (exp_rounds == 8'hFF) ? exp_rounds : exp_rounds + 8'd1;
      if (wrap && exp_rounds == N_ROUNDS) done = 1'b1;
      else exp_sel = nxt;
    end
    @(negedge Clock);
    if (done) begin
      check_eq("go_pulse", GameOver, 1);
      check_eq("go_select", Select, 0);
      check_eq("go_rounds", RoundCount, exp_rounds);
      check_eq("done_busy", Busy, 1);
      @(negedge Clock);
      check_eq("idle_busy", Busy, 0);
      check_eq("go_one_cycle", GameOver, 0);
      check_eq("rounds_hold", RoundCount, exp_rounds);
    end else begin
      check_eq("adv_turnstart", TurnStart, 1);
      check_eq("adv_select", Select, exp_sel);
      check_eq("adv_rounds", RoundCount, exp_rounds);
    end
  endtask

  initial begin
    bit         done;
    int         lat;
    logic [3:0] en;

    Reset = 1'b0; Start = 1'b0; Tick = 1'b0; ButtonVector = 3'd0; PlayerEnable = 4'd0;
    repeat (3) @(negedge Clock);
    check_eq("rst_select", Select, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_rounds", RoundCount, 0);
    check_eq("rst_movecode", MoveCode, 0);
    check_eq("rst_pulses", {TurnStart, MoveValid, TurnTimeout, GameOver}, 0);
    Reset = 1'b1;
    @(negedge Clock);

    // Start with no players enabled is ignored
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check_eq("noplayer_busy", Busy, 0);
    check_eq("noplayer_ts", TurnStart, 0);

    // Four players, a press each turn: 1,2,3,4,1 and one round done
    start_game(4'hF);
    for (int t = 0; t < 4; t++) do_turn(1'b0, 3'($urandom_range(1, 7)), 4'hF, done);
    check_eq("four_rounds", RoundCount, 1);
    check_eq("four_select", Select, 1);

    // Players 1 and 3, two rounds: 1,3,1,3 then GameOver
    do_reset();
    start_game(4'b0101);
    for (int t = 0; t < 4; t++) do_turn(1'b0, 3'($urandom_range(1, 7)), 4'b0101, done);
    check_eq("two_round_end_rounds", RoundCount, 2);

    // Timeout advances the turn
    do_reset();
    start_game(4'hF);
    do_turn(1'b1, 3'd0, 4'hF, done);
    check_eq("timeout_sel", Select, 2);

    // Press and third tick land in the same cycle
    do_reset();
    start_game(4'hF);
    repeat (4) @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      Tick = 1'b1; @(negedge Clock); Tick = 1'b0; @(negedge Clock);
    end
    ButtonVector = 3'b110;
    repeat (2) @(negedge Clock);
    Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    check_eq("tie_movevalid", MoveValid, 1);
    check_eq("tie_timeout", TurnTimeout, 0);
    check_eq("tie_code", MoveCode, 3'b110);
    ButtonVector = 3'd0;
    @(negedge Clock);
    check_eq("tie_next_sel", Select, 2);

    // Button held across the turn change does not count as a move
    do_reset();
    start_game(4'hF);
    repeat (4) @(negedge Clock);
    ButtonVector = 3'b010;
    wait_move(lat);
    check_eq("hold_first_code", MoveCode, 3'b010);
    @(negedge Clock);
    check_eq("hold_ts", TurnStart, 1);
    check_eq("hold_sel", Select, 2);
    repeat (8) begin
      @(negedge Clock);
      check_eq("hold_no_move", MoveValid, 0);
    end
    ButtonVector = 3'd0;
    repeat (4) @(negedge Clock);
    ButtonVector = 3'b101;
    wait_move(lat);
    check_eq("hold_fresh_code", MoveCode, 3'b101);
    ButtonVector = 3'd0;

    // Asynchronous reset in the middle of player 2's turn
    do_reset();
    start_game(4'hF);
    for (int t = 0; t < 5; t++) do_turn(1'b0, 3'b011, 4'hF, done);
    repeat (4) @(negedge Clock);
    check_eq("pre_rst_sel", Select, 2);
    check_eq("pre_rst_rounds", RoundCount, 1);
    #2 Reset = 1'b0;
    #1;
    check_eq("arst_select", Select, 0);
    check_eq("arst_busy", Busy, 0);
    check_eq("arst_rounds", RoundCount, 0);
    check_eq("arst_movecode", MoveCode, 0);
    check_eq("arst_pulses", {TurnStart, MoveValid, TurnTimeout, GameOver}, 0);
    @(negedge Clock);
    Reset = 1'b1;
    PlayerEnable = 4'd0;
    Start = 1'b1;
    repeat (2) @(negedge Clock);
    Start = 1'b0;
    check_eq("arst_noplayer_busy", Busy, 0);

    // Random games
    for (int g = 0; g < 25; g++) begin
      en = 4'($urandom_range(1, 15));
      start_game(en);
      done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
        en = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        do_turn($urandom_range(0, 3) == 0, 3'($urandom_range(1, 7)), en, done);
      end
      if (!done) do_reset();
    end

    finish_run();
  end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 The module SHALL have parameter TIMEOUT_TICKS, default 1000: Tick pulses allowed per turn before a forced advance.
REQ-002 The module SHALL have parameter NUM_ROUNDS, default 8: completed rounds per game.
REQ-003 The module SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port Start, input, 1 bit: begins a game, honoured only in IDLE.
REQ-006 The module SHALL have port PlayerEnable, input, 4 bits: bit i marks player i+1 as participating.
REQ-007 The module SHALL have port Tick, input, 1 bit: single-cycle timebase strobe for the turn timer.
REQ-008 The module SHALL have port ButtonVector, input, 3 bits: raw asynchronous buttons from the shared controller.
REQ-009 The module SHALL have port Select, output, 3 bits: 0 = no player, 1-4 = active player; drives the button decoder's Select.
REQ-010 The module SHALL have port TurnStart, output, 1 bit: one-cycle pulse when Select takes a new player.
REQ-011 The module SHALL have port MoveValid, output, 1 bit: one-cycle pulse marking an accepted press.
REQ-012 The module SHALL have port MoveCode, output, 3 bits: synchronized button vector captured with MoveValid, held until the next MoveValid.
REQ-013 The module SHALL have port TurnTimeout, output, 1 bit: one-cycle pulse when a turn expires.
REQ-014 The module SHALL have port RoundCount, output, 8 bits: completed rounds in the current or last game.
REQ-015 The module SHALL have port GameOver, output, 1 bit: one-cycle pulse at game end.
REQ-016 The module SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 ButtonVector SHALL pass through a 2-flop synchronizer; "press" SHALL mean a rising edge on any bit of the synchronized vector.
REQ-018 The FSM SHALL have the states IDLE, ARM, ACTIVE, ADVANCE and DONE.
REQ-019 In IDLE, when Start=1 and PlayerEnable!=0, the next cycle SHALL enter ARM with Select = lowest enabled player, TurnStart=1 and RoundCount=0.
REQ-020 In IDLE, Start SHALL be ignored when PlayerEnable==0.
REQ-021 In ARM, the FSM SHALL stay until the synchronized buttons are all 0, then enter ACTIVE with the turn timer cleared, so a held button never counts as a move.
REQ-022 In ACTIVE, the timer SHALL increment on each Tick.
REQ-023 In ACTIVE, a press SHALL produce MoveValid=1 with MoveCode = synchronized vector in the same cycle, followed by ADVANCE.
REQ-024 In ACTIVE, when the timer count reaches TIMEOUT_TICKS, the FSM SHALL produce TurnTimeout=1 and go to ADVANCE.
REQ-025 When a press and the timeout occur in the same cycle, the press SHALL win and TurnTimeout SHALL stay 0.
REQ-026 ADVANCE SHALL last one cycle and pick the next enabled player by round-robin from Select+1, wrapping 4 to 1; PlayerEnable SHALL be sampled only here.
REQ-027 A wrap SHALL occur when next <= current, which includes the single-enabled-player case, and SHALL increment RoundCount.
REQ-028 If the incremented RoundCount equals NUM_ROUNDS, the FSM SHALL enter DONE; otherwise it SHALL drive Select=next, TurnStart=1 and enter ARM.
REQ-029 If PlayerEnable==0 in ADVANCE, the FSM SHALL enter DONE without incrementing RoundCount.
REQ-030 DONE SHALL last one cycle with GameOver=1 and Select=0, then go to IDLE; RoundCount SHALL hold until the next accepted Start.
REQ-031 Start outside IDLE SHALL be ignored.
REQ-032 Select SHALL be a registered output and SHALL be 0 in IDLE and DONE.
REQ-033 The timer width SHALL be $clog2(TIMEOUT_TICKS+1); the RoundCount increment SHALL saturate at 255.

Reset
REQ-034 Reset=0 SHALL immediately force IDLE, Select=0, all pulses=0, MoveCode=0, RoundCount=0, Busy=0, timer=0 and synchronizer flops=0, including mid-turn.
REQ-035 The first Start accepted after reset deassertion SHALL behave as in REQ-019.

Structure
REQ-036 A shared package turn_pkg SHALL hold the state encoding constants (3-bit), the player-count constant 4 and the default parameter values.
REQ-037 The synchronizer and rising-edge detector SHALL be one sub-module, button_sync (3-bit, Clock/Reset, outputs Synced[2:0] and Rise[2:0]).

Verification
REQ-038 With PlayerEnable=4'b1111 and Start, then a press in each turn: Select SHALL step 1,2,3,4,1 and RoundCount SHALL be 1 after the fourth move.
REQ-039 With PlayerEnable=4'b0101, NUM_ROUNDS=2 and presses each turn: Select SHALL be 1,3,1,3, then GameOver with RoundCount=2 and Select=0.
REQ-040 With TIMEOUT_TICKS=3 and no press: TurnTimeout SHALL pulse on the third Tick in ACTIVE and Select SHALL advance.
REQ-041 With a button held through ADVANCE into ARM: no MoveValid until release, then a fresh press SHALL give MoveValid with MoveCode equal to that vector.
REQ-042 With a press and the third Tick in the same ACTIVE cycle: MoveValid=1 and TurnTimeout=0.
REQ-043 With Reset asserted in ACTIVE at Select=2: all outputs SHALL be 0 asynchronously; Start with PlayerEnable=0 SHALL then leave Busy=0.
